// File: rtl/dmem_port_if.sv
// Bundle of both requester ports and the data-memory bus
// seen by the data-memory port arbiter.
interface dmem_port_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 32
);
  logic              m0_req;
  logic              m0_we;
  logic              m0_lock;
  logic [ADDR_W-1:0] m0_addr;
  logic [WIDTH-1:0]  m0_wdata;
  logic              m0_gnt;
  logic              m0_rvalid;
  logic [WIDTH-1:0]  m0_rdata;

  logic              m1_req;
  logic              m1_we;
  logic              m1_lock;
  logic [ADDR_W-1:0] m1_addr;
  logic [WIDTH-1:0]  m1_wdata;
  logic              m1_gnt;
  logic              m1_rvalid;
  logic [WIDTH-1:0]  m1_rdata;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WIDTH-1:0]  mem_wdata;
  logic [WIDTH-1:0]  mem_rdata;

  modport master (
    output m0_req, m0_we, m0_lock,
    output m0_addr, m0_wdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    output m1_req, m1_we, m1_lock,
    output m1_addr, m1_wdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

  modport slave (
    input  m0_req, m0_we, m0_lock,
    input  m0_addr, m0_wdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    input  m1_req, m1_we, m1_lock,
    input  m1_addr, m1_wdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter with lock sharing one data memory
// between the load/store path (port 0) and the loader (port 1).
module dmem_port_arbiter #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 32
) (
  input  logic        CLK,
  input  logic        RST,
  dmem_port_if.slave  bus
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P0   = 2'd1,
    OWN_P1   = 2'd2
  } owner_e;

  owner_e owner_q, owner_d;
  logic   last_q, last_d;
  logic   rv0_q, rv0_d;
  logic   rv1_q, rv1_d;

  logic              gnt0, gnt1;
  logic              mwe;
  logic [ADDR_W-1:0] maddr;
  logic [WIDTH-1:0]  mwdata;

  // Grants are held off while reset is applied.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    unique case (owner_q)
      OWN_P0: gnt0 = bus.m0_req;
      OWN_P1: gnt1 = bus.m1_req;
      default: begin
        if (bus.m0_req && bus.m1_req) begin
          gnt0 = last_q;
          gnt1 = ~last_q;
        end else begin
          gnt0 = bus.m0_req;
          gnt1 = bus.m1_req;
        end
      end
    endcase
    if (RST) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
  end

  always_comb begin
    owner_d = owner_q;
    last_d  = last_q;
    rv0_d   = 1'b0;
    rv1_d   = 1'b0;
    if (gnt0) begin
      last_d  = 1'b0;
      owner_d = bus.m0_lock ? OWN_P0 : OWN_NONE;
      rv0_d   = ~bus.m0_we;
    end else if (gnt1) begin
      last_d  = 1'b1;
      owner_d = bus.m1_lock ? OWN_P1 : OWN_NONE;
      rv1_d   = ~bus.m1_we;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      owner_q <= OWN_NONE;
      last_q  <= 1'b1;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
    end else begin
      owner_q <= owner_d;
      last_q  <= last_d;
      rv0_q   <= rv0_d;
      rv1_q   <= rv1_d;
    end
  end

  always_comb begin
    mwe    = 1'b0;
    maddr  = '0;
    mwdata = '0;
    if (gnt0) begin
      mwe    = bus.m0_we;
      maddr  = bus.m0_addr;
      mwdata = bus.m0_wdata;
    end else if (gnt1) begin
      mwe    = bus.m1_we;
      maddr  = bus.m1_addr;
      mwdata = bus.m1_wdata;
    end
  end

  assign bus.mem_we    = mwe;
  assign bus.mem_addr  = maddr;
  assign bus.mem_wdata = mwdata;

  assign bus.m0_gnt    = gnt0;
  assign bus.m1_gnt    = gnt1;
  assign bus.m0_rvalid = rv0_q;
  assign bus.m1_rvalid = rv1_q;
  assign bus.m0_rdata  = rv0_q ? bus.mem_rdata : '0;
  assign bus.m1_rdata  = rv1_q ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed vector table, corner
// sequences and a randomized run against a reference model.
module tb_dmem_port_arbiter;
  localparam int W = 32;
  localparam int A = 32;

  typedef struct packed {
    logic         req;
    logic         we;
    logic         lock;
    logic [31:0]  addr;
    logic [31:0]  wdata;
  } port_in_t;

  typedef struct packed {
    logic         g0;
    logic         g1;
    logic         rv0;
    logic         rv1;
    logic [31:0]  rd0;
    logic [31:0]  rd1;
    logic         mwe;
    logic [31:0]  maddr;
    logic [31:0]  mwdata;
  } exp_t;

  typedef struct packed {
    port_in_t p0;
    port_in_t p1;
    exp_t     e;
  } vec_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic ld  = 1'b1;
  always #5 CLK = ~CLK;

  dmem_port_if #(.WIDTH(W), .ADDR_W(A)) bus();

  dmem_port_arbiter #(.WIDTH(W), .ADDR_W(A)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [31:0] init_val(int i);
    if (i == 'h10) return 32'hDEADBEEF;
    if (i == 'h30) return 32'hCAFEF00D;
    return 32'(i) * 32'h9E3779B1;
  endfunction

  // Registered single-port memory: read returns the pre-write word.
  logic [31:0] mem [256];
  always @(posedge CLK) begin
    if (ld) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
    end else begin
      bus.mem_rdata <= mem[bus.mem_addr[7:0]];
      if (bus.mem_we) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
    end
  end

  task automatic chk(string nm, logic [127:0] act,
                     logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(port_in_t a, port_in_t b);
    bus.m0_req   = a.req;
    bus.m0_we    = a.we;
    bus.m0_lock  = a.lock;
    bus.m0_addr  = a.addr;
    bus.m0_wdata = a.wdata;
    bus.m1_req   = b.req;
    bus.m1_we    = b.we;
    bus.m1_lock  = b.lock;
    bus.m1_addr  = b.addr;
    bus.m1_wdata = b.wdata;
  endtask

  function automatic port_in_t P(logic r, logic w, logic l,
                                 logic [31:0] a, logic [31:0] d);
    port_in_t p;
    p.req = r; p.we = w; p.lock = l; p.addr = a; p.wdata = d;
    return p;
  endfunction

  function automatic port_in_t R(logic [31:0] a);
    return P(1'b1, 1'b0, 1'b0, a, 32'h0);
  endfunction

  function automatic exp_t E(logic g0, logic g1, logic rv0,
                             logic rv1, logic [31:0] rd0,
                             logic [31:0] rd1, logic mwe,
                             logic [31:0] ma, logic [31:0] md);
    exp_t e;
    e.g0 = g0; e.g1 = g1; e.rv0 = rv0; e.rv1 = rv1;
    e.rd0 = rd0; e.rd1 = rd1;
    e.mwe = mwe; e.maddr = ma; e.mwdata = md;
    return e;
  endfunction

  function automatic exp_t actual();
    return E(bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid,
             bus.m1_rvalid, bus.m0_rdata, bus.m1_rdata,
             bus.mem_we, bus.mem_addr, bus.mem_wdata);
  endfunction

  task automatic chk_all(string nm, exp_t e);
    exp_t a;
    a = actual();
    chk({nm, " gnt/rv"}, {a.g0, a.g1, a.rv0, a.rv1},
        {e.g0, e.g1, e.rv0, e.rv1});
    chk({nm, " rdata"}, {a.rd0, a.rd1}, {e.rd0, e.rd1});
    chk({nm, " membus"}, {a.mwe, a.maddr, a.mwdata},
        {e.mwe, e.maddr, e.mwdata});
  endtask

  task automatic step(port_in_t a, port_in_t b);
    @(posedge CLK);
    #1;
    drive(a, b);
    @(negedge CLK);
  endtask

  vec_t      vec [19];
  port_in_t  I;
  logic [31:0] ref_mem [256];

  // Reference model state for the randomized run
  int          m_last;
  int          m_owner;
  bit          exp_rv [2];
  logic [31:0] exp_rd [2];
  bit          pend [2];
  port_in_t    preq [2];

  initial begin
    I = '0;
    vec[0]  = '{R(32'h10), I,
               E(1,0,0,0,0,0,0,32'h10,0)};
    vec[1]  = '{I, I,
               E(0,0,1,0,32'hDEADBEEF,0,0,0,0)};
    vec[2]  = '{I, P(1,1,0,32'h20,32'h12345678),
               E(0,1,0,0,0,0,1,32'h20,32'h12345678)};
    vec[3]  = '{R(32'h20), R(32'h10),
               E(1,0,0,0,0,0,0,32'h20,0)};
    vec[4]  = '{R(32'h10), R(32'h10),
               E(0,1,1,0,32'h12345678,0,0,32'h10,0)};
    vec[5]  = '{R(32'h20), R(32'h20),
               E(1,0,0,1,0,32'hDEADBEEF,0,32'h20,0)};
    vec[6]  = '{R(32'h10), R(32'h20),
               E(0,1,1,0,32'h12345678,0,0,32'h20,0)};
    vec[7]  = '{R(32'h10), I,
               E(1,0,0,1,0,32'h12345678,0,32'h10,0)};
    vec[8]  = '{I, I,
               E(0,0,1,0,32'hDEADBEEF,0,0,0,0)};
    vec[9]  = '{R(32'h10), P(1,0,1,32'h30,0),
               E(0,1,0,0,0,0,0,32'h30,0)};
    vec[10] = '{R(32'h10), P(1,1,0,32'h30,32'h55AA55AA),
               E(0,1,0,1,0,32'hCAFEF00D,1,32'h30,32'h55AA55AA)};
    vec[11] = '{R(32'h10), I,
               E(1,0,0,0,0,0,0,32'h10,0)};
    vec[12] = '{R(32'h30), I,
               E(1,0,1,0,32'hDEADBEEF,0,0,32'h30,0)};
    vec[13] = '{I, I,
               E(0,0,1,0,32'h55AA55AA,0,0,0,0)};
    vec[14] = '{P(1,0,1,32'h10,0), I,
               E(1,0,0,0,0,0,0,32'h10,0)};
    vec[15] = '{I, R(32'h20),
               E(0,0,1,0,32'hDEADBEEF,0,0,0,0)};
    vec[16] = '{R(32'h10), R(32'h20),
               E(1,0,0,0,0,0,0,32'h10,0)};
    vec[17] = '{I, R(32'h20),
               E(0,1,1,0,32'hDEADBEEF,0,0,32'h20,0)};
    vec[18] = '{I, I,
               E(0,0,0,1,0,32'h12345678,0,0,0)};

    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);

    // Reset state, with a request present to show grants are held off
    drive(R(32'h10), R(32'h20));
    bus.m0_lock = 1'b0;
    @(negedge CLK);
    chk_all("reset", E(0,0,0,0,0,0,0,0,0));
    drive(I, I);
    @(posedge CLK);
    @(posedge CLK);
    #1;
    ld  = 1'b0;
    RST = 1'b0;

    foreach (vec[i]) begin
      step(vec[i].p0, vec[i].p1);
      chk_all($sformatf("vec%0d", i), vec[i].e);
    end

    // Reset one cycle after a read grant drops the rvalid
    step(R(32'h10), I);
    chk("rst_mid gnt", {bus.m0_gnt, bus.m1_gnt}, 2'b10);
    @(posedge CLK);
    #1;
    drive(I, I);
    RST = 1'b1;
    @(negedge CLK);
    chk("rst_mid rvalid", {bus.m0_rvalid, bus.m1_rvalid}, 2'b00);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    drive(R(32'h10), R(32'h20));
    @(negedge CLK);
    chk("rst_mid first", {bus.m0_gnt, bus.m1_gnt}, 2'b10);
    step(I, R(32'h20));
    chk_all("rst_mid next", E(0,1,1,0,32'hDEADBEEF,0,0,32'h20,0));
    step(I, I);
    chk_all("rst_mid last", E(0,0,0,1,0,32'h12345678,0,0,0));

    for (int i = 0; i < 10; i++) begin
      step(I, I);
      chk($sformatf("idle%0d", i),
          {bus.mem_we, bus.mem_addr, bus.m0_gnt, bus.m1_gnt,
           bus.m0_rvalid, bus.m1_rvalid}, '0);
    end

    // Randomized run on addresses 0x80..0x8F, untouched above
    @(posedge CLK);
    #1;
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    m_last  = 1;
    m_owner = -1;
    for (int k = 0; k < 2; k++) begin
      exp_rv[k] = 1'b0;
      exp_rd[k] = '0;
      pend[k]   = 1'b0;
      preq[k]   = '0;
    end

    for (int c = 0; c < 3000; c++) begin
      int   g;
      exp_t e;
      for (int k = 0; k < 2; k++) begin
        if (!pend[k] && $urandom_range(0, 2) == 0) begin
          pend[k] = 1'b1;
          preq[k] = P(1'b1, 1'($urandom_range(0, 1)),
                      $urandom_range(0, 3) == 0,
                      32'h80 + 32'($urandom_range(0, 15)),
                      $urandom);
        end
      end
      step(pend[0] ? preq[0] : I, pend[1] ? preq[1] : I);

      if (m_owner >= 0)            g = pend[m_owner] ? m_owner : -1;
      else if (pend[0] && pend[1]) g = 1 - m_last;
      else if (pend[0])            g = 0;
      else if (pend[1])            g = 1;
      else                         g = -1;

      e = E(g == 0, g == 1, exp_rv[0], exp_rv[1],
            exp_rv[0] ? exp_rd[0] : 32'h0,
            exp_rv[1] ? exp_rd[1] : 32'h0, 0, 0, 0);
      if (g >= 0) begin
        e.mwe    = preq[g].we;
        e.maddr  = preq[g].addr;
        e.mwdata = preq[g].wdata;
      end
      chk_all($sformatf("rnd%0d", c), e);

      exp_rv[0] = 1'b0;
      exp_rv[1] = 1'b0;
      if (g >= 0) begin
        m_last  = g;
        m_owner = preq[g].lock ? g : -1;
        if (preq[g].we) begin
          ref_mem[preq[g].addr[7:0]] = preq[g].wdata;
        end else begin
          exp_rv[g] = 1'b1;
          exp_rd[g] = ref_mem[preq[g].addr[7:0]];
        end
        pend[g] = 1'b0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
